// File: rtl/scalar_wb_arbiter.sv
// -----------------------------------------------------------------------------
// scalar_wb_arbiter
//
// Merges host (Wishbone side) scalar writes and coprocessor core writebacks
// into the single write port of the scalar register file.
//
// Host writes are buffered in a small FIFO. The core has priority. An
// optional starvation guard forces a host slot after STARVE_LIMIT consecutive
// core wins while the FIFO is non-empty. Writes to addresses >= REG_DEPTH are
// dropped and flag the sticky addr_error.
//
// Optional feature macro: SCALAR_WB_STARVE_GUARD_EN
//   defined   : starve counter and guard active
//   undefined : strict core priority, core_ready tied high
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   host_valid/ready/address/data  host write request into the FIFO
//   core_valid/ready/address/data  core writeback request
//   write_enable/address/data   registered register-file write port
//   fifo_count                  host FIFO occupancy
//   addr_error, error_clear     sticky out-of-range flag and its clear
// -----------------------------------------------------------------------------
module scalar_wb_arbiter #(
   parameter int REG_DEPTH    = 6,
   parameter int REG_WIDTH    = 32,
   parameter int ADDR_WIDTH   = 5,
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          host_valid,
   output logic                          host_ready,
   input  logic [ADDR_WIDTH-1:0]         host_address,
   input  logic [REG_WIDTH-1:0]          host_data,
   input  logic                          core_valid,
   output logic                          core_ready,
   input  logic [ADDR_WIDTH-1:0]         core_address,
   input  logic [REG_WIDTH-1:0]          core_data,
   output logic                          write_enable,
   output logic [ADDR_WIDTH-1:0]         write_address,
   output logic [REG_WIDTH-1:0]          write_data,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          addr_error,
   input  logic                          error_clear
);

   localparam int          PTR_W   = $clog2(FIFO_DEPTH);
   localparam int          CNT_W   = PTR_W + 1;
   localparam int unsigned DEPTH_U = REG_DEPTH;

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
      $error("FIFO_DEPTH must be a power of two and at least 2");
   end
   if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
      $error("STARVE_LIMIT must be at least 1");
   end

   logic [ADDR_WIDTH-1:0] addr_mem_q [FIFO_DEPTH];
   logic [REG_WIDTH-1:0]  data_mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;

   logic                  fifo_nonempty;
   logic                  push;
   logic                  guard;
   logic                  grant_core;
   logic                  grant_host;
   logic                  granted;
   logic                  in_range;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [REG_WIDTH-1:0]  sel_data;

   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [REG_WIDTH-1:0]  wdata_q, wdata_d;
   logic                  err_q, err_d;

   // Both handshakes depend only on registered state, so neither input
   // valid can combinationally loop back into its own ready.
   assign fifo_nonempty = (count_q != '0);
   assign host_ready    = (count_q < CNT_W'(FIFO_DEPTH));
   assign push          = host_valid && host_ready;
   assign core_ready    = !guard;

   // Grant: core first unless the guard is up; otherwise the FIFO head.
   // The head is read from registered state, so an entry enqueued this
   // cycle is never granted in the same cycle.
   always_comb begin
      grant_core = core_valid && !guard;
      grant_host = !grant_core && fifo_nonempty;
      granted    = grant_core || grant_host;
      sel_addr   = grant_core ? core_address : addr_mem_q[rd_ptr_q];
      sel_data   = grant_core ? core_data    : data_mem_q[rd_ptr_q];
      in_range   = (32'(sel_addr) < DEPTH_U);
   end

`ifdef SCALAR_WB_STARVE_GUARD_EN
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   logic [SW-1:0] starve_q, starve_d;

   assign guard = (starve_q == SW'(STARVE_LIMIT));

   // A core grant implies the guard is down, so incrementing here never
   // passes STARVE_LIMIT: the counter saturates by construction.
   always_comb begin
      starve_d = starve_q;
      if (grant_core && fifo_nonempty) begin
         starve_d = starve_q + SW'(1);
      end else if (grant_host || !fifo_nonempty) begin
         starve_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) starve_q <= '0;
      else       starve_q <= starve_d;
   end
`else
   assign guard = 1'b0;
`endif

   // FIFO pointer / occupancy next state; a full FIFO cannot push, so a
   // simultaneous pop only ever leaves the count unchanged or lowers it.
   always_comb begin
      rd_ptr_d = grant_host ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      wr_ptr_d = push       ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      count_d  = count_q + CNT_W'(push) - CNT_W'(grant_host);
   end

   // Output register next state; address/data hold when nothing is granted.
   // An out-of-range grant still consumes its slot but only raises the
   // sticky error; a set in the same cycle as a clear takes precedence.
   always_comb begin
      we_d    = granted && in_range;
      waddr_d = granted ? sel_addr : waddr_q;
      wdata_d = granted ? sel_data : wdata_q;
      err_d   = err_q;
      if (granted && !in_range) err_d = 1'b1;
      else if (error_clear)     err_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         we_q     <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         we_q     <= we_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
         err_q    <= err_d;
      end
   end

   // FIFO storage carries no reset; the pointers alone define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem_q[wr_ptr_q] <= host_address;
         data_mem_q[wr_ptr_q] <= host_data;
      end
   end

   assign write_enable  = we_q;
   assign write_address = waddr_q;
   assign write_data    = wdata_q;
   assign fifo_count    = count_q;
   assign addr_error    = err_q;

endmodule

// File: tb/tb_scalar_wb_arbiter.sv
module tb_scalar_wb_arbiter;
   localparam int REG_DEPTH    = 6;
   localparam int REG_WIDTH    = 32;
   localparam int ADDR_WIDTH   = 5;
   localparam int FIFO_DEPTH   = 4;
   localparam int STARVE_LIMIT = 8;
   localparam int CW           = $clog2(FIFO_DEPTH) + 1;
`ifdef SCALAR_WB_STARVE_GUARD_EN
   localparam bit GUARD_ON = 1'b1;
`else
   localparam bit GUARD_ON = 1'b0;
`endif

   logic                  clk = 1'b0;
   logic                  reset = 1'b1;
   logic                  host_valid = 1'b0;
   logic                  host_ready;
   logic [ADDR_WIDTH-1:0] host_address = '0;
   logic [REG_WIDTH-1:0]  host_data = '0;
   logic                  core_valid = 1'b0;
   logic                  core_ready;
   logic [ADDR_WIDTH-1:0] core_address = '0;
   logic [REG_WIDTH-1:0]  core_data = '0;
   logic                  write_enable;
   logic [ADDR_WIDTH-1:0] write_address;
   logic [REG_WIDTH-1:0]  write_data;
   logic [CW-1:0]         fifo_count;
   logic                  addr_error;
   logic                  error_clear = 1'b0;

   scalar_wb_arbiter #(
      .REG_DEPTH(REG_DEPTH), .REG_WIDTH(REG_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
      .FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk(clk), .reset(reset),
      .host_valid(host_valid), .host_ready(host_ready),
      .host_address(host_address), .host_data(host_data),
      .core_valid(core_valid), .core_ready(core_ready),
      .core_address(core_address), .core_data(core_data),
      .write_enable(write_enable), .write_address(write_address),
      .write_data(write_data), .fifo_count(fifo_count),
      .addr_error(addr_error), .error_clear(error_clear)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] a;
      logic [REG_WIDTH-1:0]  d;
   } wr_t;
   typedef struct {
      logic [ADDR_WIDTH-1:0] a;
      logic [REG_WIDTH-1:0]  d;
      int                    cyc;
   } exp_t;

   // Reference model state: pending host writes, expected register-file
   // writes (with the cycle they must appear), starvation run, error flag.
   wr_t  hq[$];
   exp_t expq[$];
   int   starve = 0;
   bit   err_m = 1'b0;
   bit   after_rst = 1'b0;
   bit   mon_en = 1'b0;
   int   cyc = 0;
   int   cr_low = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   exp_t mon_e;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock cycle: drive inputs, check outputs against the model, then
   // advance the model by the arbitration rules for this cycle.
   task automatic step(input bit r, input bit hv, input logic [ADDR_WIDTH-1:0] ha,
                       input logic [REG_WIDTH-1:0] hd, input bit cv,
                       input logic [ADDR_WIDTH-1:0] ca, input logic [REG_WIDTH-1:0] cd,
                       input bit ec);
      bit  guard, cwin, hwin, hr, nonempty, set;
      wr_t w;
      @(negedge clk);
      reset = r; host_valid = hv; host_address = ha; host_data = hd;
      core_valid = cv; core_address = ca; core_data = cd; error_clear = ec;
      #1;
      guard    = GUARD_ON && (starve == STARVE_LIMIT);
      hr       = (hq.size() < FIFO_DEPTH);
      nonempty = (hq.size() > 0);
      chk("fifo_count", 64'(fifo_count), 64'(hq.size()));
      chk("host_ready", 64'(host_ready), 64'(hr));
      chk("core_ready", 64'(core_ready), 64'(!guard));
      chk("addr_error", 64'(addr_error), 64'(err_m));
      if (!core_ready) cr_low++;
      if (after_rst) begin
         chk("rst_write_enable",  64'(write_enable),  64'(0));
         chk("rst_write_address", 64'(write_address), 64'(0));
         chk("rst_write_data",    64'(write_data),    64'(0));
      end
      if (r) begin
         hq.delete();
         expq.delete();
         starve    = 0;
         err_m     = 1'b0;
         after_rst = 1'b1;
      end else begin
         after_rst = 1'b0;
         cwin = cv && !guard;
         hwin = !cwin && nonempty;
         w    = '0;
         if (cwin)      w = '{ca, cd};
         else if (hwin) w = hq.pop_front();
         set = (cwin || hwin) && (int'(w.a) >= REG_DEPTH);
         if ((cwin || hwin) && !set) expq.push_back('{w.a, w.d, cyc + 1});
         if (set)     err_m = 1'b1;
         else if (ec) err_m = 1'b0;
         if (cwin && nonempty)      starve = (starve < STARVE_LIMIT) ? starve + 1 : starve;
         else if (hwin || !nonempty) starve = 0;
         if (hv && hr) hq.push_back('{ha, hd});
      end
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, '0, '0, 0);
   endtask

   // Monitor: every register-file write must match the head of the expected
   // queue and appear in exactly the predicted cycle.
   always @(posedge clk) begin
      #1;
      cyc++;
      if (mon_en && write_enable !== 1'b0) begin
         if (expq.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_write: got addr=%0d data=%0h, expected no write (cycle %0d)",
                     write_address, write_data, cyc);
         end else begin
            mon_e = expq.pop_front();
            chk("wr_address", 64'(write_address), 64'(mon_e.a));
            chk("wr_data",    64'(write_data),    64'(mon_e.d));
            chk("wr_cycle",   64'(cyc),           64'(mon_e.cyc));
         end
      end
      if (mon_en && expq.size() > 0 && expq[0].cyc <= cyc) begin
         mon_e = expq.pop_front();
         n_checks++;
         n_errors++;
         $display("FAIL missing_write: got write_enable=%b, expected addr=%0d data=%0h (cycle %0d)",
                  write_enable, mon_e.a, mon_e.d, cyc);
      end
   end

   initial begin
      bit acc;
      int guard_cnt;
      int pct;
      // Power-up reset, with a host request held high throughout.
      repeat (2) @(posedge clk);
      after_rst = 1'b1;
      mon_en    = 1'b1;
      step(1, 1, 5'd2, 32'h1111_0000, 0, '0, '0, 0);
      step(1, 1, 5'd2, 32'h1111_0000, 0, '0, '0, 0);
      idle(1);

      // Single core write.
      step(0, 0, '0, '0, 1, 5'd3, 32'hDEAD_BEEF, 0);
      idle(3);

      // Host burst while the core is busy: fill to FIFO_DEPTH, then the
      // fifth entry waits for space.
      for (int i = 0; i < 4; i++)
         step(0, 1, 5'(i), 32'hA000_0000 + 32'(i), 1, 5'd5, 32'hC000_0000 + 32'(i), 0);
      guard_cnt = 0;
      do begin
         acc = (hq.size() < FIFO_DEPTH);
         step(0, 1, 5'd4, 32'hA000_0004, 0, '0, '0, 0);
         guard_cnt++;
      end while (!acc && guard_cnt < 20);
      chk("fifth_host_accepted", 64'(acc), 64'(1));
      idle(8);
      chk("burst_drained", 64'(fifo_count), 64'(0));

      // Starvation: one host entry queued against a continuously valid core.
      cr_low = 0;
      step(0, 1, 5'd1, 32'h5757_5757, 1, 5'd0, 32'h0, 0);
      for (int i = 0; i < 12; i++) step(0, 0, '0, '0, 1, 5'd0, 32'(i), 0);
      chk("guard_slots", 64'(cr_low), GUARD_ON ? 64'(1) : 64'(0));
      chk("host_pending", 64'(fifo_count), GUARD_ON ? 64'(0) : 64'(1));
      idle(3);

      // Out-of-range core write, then a host write to address 6 granted
      // in the same cycle error_clear is asserted.
      step(0, 0, '0, '0, 1, 5'd7, 32'h0BAD_0007, 0);
      step(0, 1, 5'd6, 32'h0BAD_0006, 0, '0, '0, 0);
      step(0, 0, '0, '0, 0, '0, '0, 1);
      step(0, 0, '0, '0, 0, '0, '0, 0);
      chk("err_set_wins", 64'(addr_error), 64'(1));
      step(0, 0, '0, '0, 0, '0, '0, 1);
      idle(1);

      // Reset while three host entries are buffered.
      for (int i = 0; i < 3; i++)
         step(0, 1, 5'(i + 1), 32'hBEEF_0000 + 32'(i), 1, 5'd2, 32'h2222_0000 + 32'(i), 0);
      step(1, 0, '0, '0, 0, '0, '0, 0);
      idle(1);
      chk("fifo_flushed", 64'(fifo_count), 64'(0));
      idle(4);

      // Randomized traffic at three core load levels.
      for (int ph = 0; ph < 3; ph++) begin
         pct = (ph == 0) ? 20 : (ph == 1) ? 60 : 95;
         for (int i = 0; i < 300; i++)
            step($urandom_range(0, 149) == 0, $urandom_range(0, 1) == 1,
                 ADDR_WIDTH'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 99) < pct, ADDR_WIDTH'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 9) == 0);
      end

      idle(20);
      chk("expected_drained", 64'(expq.size()), 64'(0));
      chk("final_fifo_count", 64'(fifo_count), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
